eth_phy_link_monitor: RTL and testbench
=======================================

Name: eth_phy_link_monitor

Overview:
- Sits directly downstream of the 10GBASE-R transceiver/PHY wrapper, in the phy_rx_clk domain.
- Consumes the PHY receive status outputs: block lock, high BER, rx_status, bad block, sequence error and error count.
- Produces a debounced link_up, a link state code and saturating statistics counters.
- Issues a timed receive-datapath reset request when block lock is not acquired within a timeout.

Parameters:
- CNT_WIDTH, 32: width of every statistics counter.
- LINK_UP_CYCLES, 16384: consecutive cycles of rx_status=1 required in STABLE before entering UP. Must be >=1.
- LOCK_TIMEOUT, 1000000: cycles in DOWN without rx_block_lock before a reset request is issued. Must be >=1.
- RESET_CYCLES, 64: width of the reset_req pulse, in cycles. Must be >=1.

Ports:
- clk  in  1  PHY receive clock (phy_rx_clk).
- rst  in  1  synchronous, active-high reset.
- rx_block_lock  in  1  PHY block lock.
- rx_high_ber  in  1  PHY high-BER flag. Status only; passed to high_ber_count.
- rx_status  in  1  PHY receive status (lock and no high BER).
- rx_bad_block  in  1  single-cycle bad-block pulse.
- rx_sequence_error  in  1  single-cycle sequence-error pulse.
- rx_error_count  in  7  per-cycle error increment.
- clear_counters  in  1  synchronous clear of all counters.
- link_up  out  1  1 while state==UP.
- link_state  out  2  0=DOWN, 1=STABLE, 2=UP, 3=RESET.
- reset_req  out  1  1 while state==RESET.
- link_down_count  out  CNT_WIDTH  number of UP->DOWN transitions.
- bad_block_count  out  CNT_WIDTH  count of rx_bad_block pulses.
- seq_error_count  out  CNT_WIDTH  count of rx_sequence_error pulses.
- error_total  out  CNT_WIDTH  running sum of rx_error_count.
- high_ber_count  out  CNT_WIDTH  count of rising edges of rx_high_ber.

Behaviour:
- Reset: all outputs 0, state=DOWN, timer=0, high-BER edge register=0.
- All outputs are decoded or driven directly from registers, so they change on the same edge as state or counters. There is no combinational input-to-output path.
- Timer width is clog2(max(LOCK_TIMEOUT, LINK_UP_CYCLES, RESET_CYCLES)+1). The timer clears on every state change.
- DOWN:
  - rx_status=1 -> STABLE. This takes priority over the timeout.
  - Otherwise, rx_block_lock=1 holds the timer at 0.
  - Otherwise, timer==LOCK_TIMEOUT-1 -> RESET.
  - Otherwise, timer+1.
- STABLE:
  - rx_status=0 -> DOWN.
  - Otherwise, timer==LINK_UP_CYCLES-1 -> UP.
  - Otherwise, timer+1.
  - If rx_status is first sampled 1 at edge k, link_up rises at edge k+LINK_UP_CYCLES, provided rx_status stays 1.
- UP:
  - rx_status=0 -> DOWN. link_down_count increments on that same edge.
  - rx_block_lock and rx_high_ber are otherwise ignored; the PHY folds them into rx_status.
- RESET:
  - reset_req=1.
  - timer==RESET_CYCLES-1 -> DOWN. Otherwise, timer+1.
  - Inputs are ignored, so the pulse is exactly RESET_CYCLES cycles.
  - Lock still absent afterwards -> the cycle repeats with period LOCK_TIMEOUT+RESET_CYCLES.
- Counters:
  - All counters saturate at all-ones and never wrap.
  - error_total adds the zero-extended rx_error_count each cycle. A sum that exceeds all-ones clamps to all-ones.
  - high_ber_count increments when rx_high_ber=1 and the previous-cycle value was 0.
  - clear_counters=1 zeroes every counter on that edge and overrides any simultaneous increment, including the link_down increment on UP->DOWN.
  - clear_counters does not affect state, timer or link_up.
- rst asserted mid-operation (e.g. during RESET): on that edge reset_req=0, link_up=0, state=DOWN and all counters=0.

Test Plan:
1. Reset defaults: hold rst for 4 cycles with all inputs 1 -> every output 0 and link_state=0 during and one cycle after rst. First edge after release -> link_state=1.
2. Debounce, LINK_UP_CYCLES=16: raise rx_status and rx_block_lock, first sampled at edge k -> link_state=1 from k, link_up=1 from k+16 and not earlier.
3. Glitch in STABLE: drop rx_status for 1 cycle at 10 cycles into STABLE -> state DOWN, link_up stays 0, link_down_count stays 0. The next rise restarts the full 16-cycle debounce.
4. Lock timeout, LOCK_TIMEOUT=100, RESET_CYCLES=8, rx_block_lock=0 -> reset_req high exactly 8 cycles beginning 100 cycles after reset release, then again 108 cycles later. Assert rst during the second pulse -> reset_req=0 on that edge.
5. Link drops with CNT_WIDTH=4: after reaching UP, drop rx_status -> link_up=0 and link_down_count=1 on the same edge. Repeat 20 times -> count holds at 15. A drop coincident with clear_counters -> count=0.
6. Accumulation and clear, CNT_WIDTH=16:
   - rx_error_count=100 for 3 cycles -> error_total=300.
   - rx_bad_block pulsed 5 times -> bad_block_count=5.
   - rx_high_ber held high for 10 cycles -> high_ber_count=1.
   - clear_counters with a simultaneous rx_bad_block -> all counters 0 on the next cycle.

Source files
------------

// File: rtl/eth_phy_link_monitor.sv
// Purpose : 10GBASE-R receive link monitor. It debounces rx_status into link_up, forces periodic
//           receive-datapath resets while block lock is missing, and keeps saturating receive statistics.
// Latency : all outputs are registered or decoded from registers and change on the edge that updates state or counters.
// Backpr. : none. Status inputs are sampled every cycle and cannot be stalled.
//
// Ports:
//   clk, rst            phy_rx_clk domain; rst is synchronous and active-high
//   rx_block_lock       PHY block lock; holds the lock-timeout timer at zero while in DOWN
//   rx_high_ber         PHY high-BER flag; each rising edge is counted
//   rx_status           PHY receive status (lock and not high BER); drives the link FSM
//   rx_bad_block        single-cycle pulse, counted
//   rx_sequence_error   single-cycle pulse, counted
//   rx_error_count      per-cycle error increment, accumulated
//   clear_counters      synchronous clear of every statistics counter
//   link_up             1 while the FSM is in UP
//   link_state          0=DOWN, 1=STABLE, 2=UP, 3=RESET
//   reset_req           1 while the FSM is in RESET (receive-datapath reset request)
//   *_count/error_total saturating statistics, CNT_WIDTH bits each

module eth_phy_link_monitor #(
   parameter int CNT_WIDTH      = 32,
   parameter int LINK_UP_CYCLES = 16384,
   parameter int LOCK_TIMEOUT   = 1000000,
   parameter int RESET_CYCLES   = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_block_lock,
   input  logic                 rx_high_ber,
   input  logic                 rx_status,
   input  logic                 rx_bad_block,
   input  logic                 rx_sequence_error,
   input  logic [6:0]           rx_error_count,
   input  logic                 clear_counters,
   output logic                 link_up,
   output logic [1:0]           link_state,
   output logic                 reset_req,
   output logic [CNT_WIDTH-1:0] link_down_count,
   output logic [CNT_WIDTH-1:0] bad_block_count,
   output logic [CNT_WIDTH-1:0] seq_error_count,
   output logic [CNT_WIDTH-1:0] error_total,
   output logic [CNT_WIDTH-1:0] high_ber_count
);

   // One shared timer, sized for the longest of the three intervals.
   localparam int MAX_AB  = (LOCK_TIMEOUT > LINK_UP_CYCLES) ? LOCK_TIMEOUT : LINK_UP_CYCLES;
   localparam int MAX_CYC = (MAX_AB > RESET_CYCLES) ? MAX_AB : RESET_CYCLES;
   localparam int TW      = $clog2(MAX_CYC + 1);

   localparam logic [TW-1:0] LOCK_LAST  = TW'(LOCK_TIMEOUT - 1);
   localparam logic [TW-1:0] UP_LAST    = TW'(LINK_UP_CYCLES - 1);
   localparam logic [TW-1:0] RESET_LAST = TW'(RESET_CYCLES - 1);

   // The error adder is one bit wider than the larger operand so that overflow is visible before clamping.
   localparam int SW = ((CNT_WIDTH > 7) ? CNT_WIDTH : 7) + 1;
   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_DOWN   = 2'd0,
      ST_STABLE = 2'd1,
      ST_UP     = 2'd2,
      ST_RESET  = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          high_ber_q;
   logic          link_drop;
   logic          ber_rise;
   logic [SW-1:0] err_sum;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_DOWN;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      case (state_q)
         ST_DOWN: begin
            // A good rx_status beats the timeout, even on the timeout cycle.
            if (rx_status) begin
               state_d = ST_STABLE;
               timer_d = '0;
            end else if (rx_block_lock) begin
               timer_d = '0;
            end else if (timer_q == LOCK_LAST) begin
               state_d = ST_RESET;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_STABLE: begin
            if (!rx_status) begin
               state_d = ST_DOWN;
               timer_d = '0;
            end else if (timer_q == UP_LAST) begin
               state_d = ST_UP;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         ST_UP: begin
            // Lock and high BER are already folded into rx_status by the PHY.
            if (!rx_status) begin
               state_d = ST_DOWN;
               timer_d = '0;
            end
         end
         ST_RESET: begin
            // Inputs are ignored here so the reset pulse always has its full width.
            if (timer_q == RESET_LAST) begin
               state_d = ST_DOWN;
               timer_d = '0;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         default: begin
            state_d = ST_DOWN;
            timer_d = '0;
         end
      endcase
   end

   assign link_state = state_q;
   assign link_up    = (state_q == ST_UP);
   assign reset_req  = (state_q == ST_RESET);

   // ---------------------------------------------------------------- statistics
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_WIDTH'(1);
   endfunction

   assign link_drop = (state_q == ST_UP) && !rx_status;
   assign ber_rise  = rx_high_ber && !high_ber_q;
   assign err_sum   = SW'(error_total) + SW'(rx_error_count);

   // The previous-cycle high-BER flag is not a statistic, so clear_counters leaves it alone.
   always_ff @(posedge clk) begin
      if (rst) begin
         high_ber_q <= 1'b0;
      end else begin
         high_ber_q <= rx_high_ber;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear_counters) begin
         link_down_count <= '0;
         bad_block_count <= '0;
         seq_error_count <= '0;
         error_total     <= '0;
         high_ber_count  <= '0;
      end else begin
         if (link_drop) begin
            link_down_count <= sat_inc(link_down_count);
         end
         if (rx_bad_block) begin
            bad_block_count <= sat_inc(bad_block_count);
         end
         if (rx_sequence_error) begin
            seq_error_count <= sat_inc(seq_error_count);
         end
         if (ber_rise) begin
            high_ber_count <= sat_inc(high_ber_count);
         end
         error_total <= (err_sum > SW'(CNT_MAX)) ? CNT_MAX : err_sum[CNT_WIDTH-1:0];
      end
   end

endmodule

// File: tb/tb_eth_phy_link_monitor.sv
// Purpose : directed testbench for eth_phy_link_monitor, using short timing parameters.
// Latency : outputs are sampled 1 time unit after each rising edge, and inputs are driven at the same moment.
// Backpr. : not applicable.

module tb_eth_phy_link_monitor;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_block_lock, rx_high_ber, rx_status, rx_bad_block, rx_sequence_error;
   logic [6:0]  rx_error_count;
   logic        clear_counters;

   // Instance with 16-bit counters.
   logic        link_up, reset_req;
   logic [1:0]  link_state;
   logic [15:0] link_down_count, bad_block_count, seq_error_count, error_total, high_ber_count;

   // Instance with 4-bit counters, used for the saturation checks.
   logic        c4_link_up, c4_reset_req;
   logic [1:0]  c4_link_state;
   logic [3:0]  c4_link_down_count, c4_bad_block_count, c4_seq_error_count, c4_error_total, c4_high_ber_count;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   eth_phy_link_monitor #(
      .CNT_WIDTH(16), .LINK_UP_CYCLES(16), .LOCK_TIMEOUT(100), .RESET_CYCLES(8)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber), .rx_status(rx_status),
      .rx_bad_block(rx_bad_block), .rx_sequence_error(rx_sequence_error),
      .rx_error_count(rx_error_count), .clear_counters(clear_counters),
      .link_up(link_up), .link_state(link_state), .reset_req(reset_req),
      .link_down_count(link_down_count), .bad_block_count(bad_block_count),
      .seq_error_count(seq_error_count), .error_total(error_total),
      .high_ber_count(high_ber_count)
   );

   eth_phy_link_monitor #(
      .CNT_WIDTH(4), .LINK_UP_CYCLES(16), .LOCK_TIMEOUT(100), .RESET_CYCLES(8)
   ) dut_c4 (
      .clk(clk), .rst(rst),
      .rx_block_lock(rx_block_lock), .rx_high_ber(rx_high_ber), .rx_status(rx_status),
      .rx_bad_block(rx_bad_block), .rx_sequence_error(rx_sequence_error),
      .rx_error_count(rx_error_count), .clear_counters(clear_counters),
      .link_up(c4_link_up), .link_state(c4_link_state), .reset_req(c4_reset_req),
      .link_down_count(c4_link_down_count), .bad_block_count(c4_bad_block_count),
      .seq_error_count(c4_seq_error_count), .error_total(c4_error_total),
      .high_ber_count(c4_high_ber_count)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rx_block_lock     = 1'b1;
      rx_high_ber       = 1'b0;
      rx_status         = 1'b0;
      rx_bad_block      = 1'b0;
      rx_sequence_error = 1'b0;
      rx_error_count    = 7'd0;
      clear_counters    = 1'b0;
   endtask

   // Returns with rst just released; the next step() is the first edge after release.
   task automatic apply_reset();
      rst = 1'b1;
      idle_inputs();
      repeat (2) step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_block_lock = 1'b1; rx_high_ber = 1'b1; rx_status = 1'b1; rx_bad_block = 1'b1;
      rx_sequence_error = 1'b1; rx_error_count = 7'h7F; clear_counters = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({link_up, reset_req, link_state} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_ctrl cyc%0d: got up=%b req=%b st=%0d, want 0/0/0", i, link_up, reset_req, link_state);
         end
         checks++;
         if ({link_down_count, bad_block_count, seq_error_count, error_total, high_ber_count} !== 80'd0) begin
            errors++;
            $display("FAIL reset_cnt cyc%0d: got %0d %0d %0d %0d %0d, want all 0", i,
                     link_down_count, bad_block_count, seq_error_count, error_total, high_ber_count);
         end
      end
      rst = 1'b0;
      #2;
      checks++;
      if ({link_up, reset_req, link_state} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_after: got up=%b req=%b st=%0d, want 0/0/0", link_up, reset_req, link_state);
      end
      step();
      checks++;
      if (link_state !== 2'd1 || link_up !== 1'b0 || reset_req !== 1'b0) begin
         errors++;
         $display("FAIL reset_first_edge: got st=%0d up=%b req=%b, want 1/0/0", link_state, link_up, reset_req);
      end
      checks++;
      if (error_total !== 16'd0) begin
         errors++;
         $display("FAIL reset_clear_hold: error_total got %0d want 0", error_total);
      end
   endtask

   task automatic test_debounce();
      logic [1:0] exp_st;
      apply_reset();
      rx_status = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         step();
         exp_st = (i < 16) ? 2'd1 : 2'd2;
         checks++;
         if (link_state !== exp_st || link_up !== (i == 16)) begin
            errors++;
            $display("FAIL debounce k+%0d: got st=%0d up=%b, want st=%0d up=%b", i, link_state, link_up, exp_st, (i == 16));
         end
      end
   endtask

   task automatic test_glitch();
      logic [1:0] exp_st;
      apply_reset();
      rx_status = 1'b1;
      repeat (10) step();
      rx_status = 1'b0;
      step();
      checks++;
      if (link_state !== 2'd0 || link_up !== 1'b0 || link_down_count !== 16'd0) begin
         errors++;
         $display("FAIL glitch_drop: got st=%0d up=%b ldc=%0d, want 0/0/0", link_state, link_up, link_down_count);
      end
      rx_status = 1'b1;
      for (int i = 0; i <= 16; i++) begin
         step();
         exp_st = (i < 16) ? 2'd1 : 2'd2;
         checks++;
         if (link_state !== exp_st || link_up !== (i == 16)) begin
            errors++;
            $display("FAIL glitch_redebounce k+%0d: got st=%0d up=%b, want st=%0d up=%b", i, link_state, link_up, exp_st, (i == 16));
         end
      end
      checks++;
      if (link_down_count !== 16'd0) begin
         errors++;
         $display("FAIL glitch_ldc: got %0d want 0", link_down_count);
      end
   endtask

   task automatic test_lock_timeout();
      logic exp_req;
      apply_reset();
      rx_block_lock = 1'b0;
      for (int e = 1; e <= 212; e++) begin
         if (e == 211) rst = 1'b1;
         step();
         exp_req = ((e >= 100 && e <= 107) || (e >= 208 && e <= 210));
         checks++;
         if (reset_req !== exp_req || link_state !== (exp_req ? 2'd3 : 2'd0)) begin
            errors++;
            $display("FAIL timeout edge%0d: got req=%b st=%0d, want req=%b", e, reset_req, link_state, exp_req);
         end
      end
      rst = 1'b0;
   endtask

   task automatic test_link_drops();
      int exp_c4;
      apply_reset();
      for (int n = 1; n <= 20; n++) begin
         rx_status = 1'b1;
         repeat (17) step();
         checks++;
         if (link_up !== 1'b1) begin
            errors++;
            $display("FAIL drop_up n%0d: link_up got %b want 1", n, link_up);
         end
         rx_status = 1'b0;
         step();
         exp_c4 = (n > 15) ? 15 : n;
         checks++;
         if (link_up !== 1'b0 || link_down_count !== 16'(n) || c4_link_down_count !== 4'(exp_c4)) begin
            errors++;
            $display("FAIL drop_count n%0d: got up=%b ldc=%0d c4=%0d, want 0/%0d/%0d", n, link_up, link_down_count,
                     c4_link_down_count, n, exp_c4);
         end
      end
      rx_status = 1'b1;
      repeat (17) step();
      rx_status = 1'b0;
      clear_counters = 1'b1;
      step();
      clear_counters = 1'b0;
      checks++;
      if (link_up !== 1'b0 || link_state !== 2'd0 || link_down_count !== 16'd0 || c4_link_down_count !== 4'd0) begin
         errors++;
         $display("FAIL drop_clear: got up=%b st=%0d ldc=%0d c4=%0d, want 0/0/0/0", link_up, link_state,
                  link_down_count, c4_link_down_count);
      end
   endtask

   task automatic test_accumulate();
      apply_reset();
      rx_error_count = 7'd100;
      repeat (3) step();
      rx_error_count = 7'd0;
      checks++;
      if (error_total !== 16'd300 || c4_error_total !== 4'd15) begin
         errors++;
         $display("FAIL err_total: got %0d c4=%0d, want 300/15", error_total, c4_error_total);
      end
      for (int i = 0; i < 5; i++) begin
         rx_bad_block = 1'b1; step();
         rx_bad_block = 1'b0; step();
      end
      checks++;
      if (bad_block_count !== 16'd5) begin
         errors++;
         $display("FAIL bad_block: got %0d want 5", bad_block_count);
      end
      for (int i = 0; i < 3; i++) begin
         rx_sequence_error = 1'b1; step();
         rx_sequence_error = 1'b0; step();
      end
      checks++;
      if (seq_error_count !== 16'd3) begin
         errors++;
         $display("FAIL seq_error: got %0d want 3", seq_error_count);
      end
      rx_high_ber = 1'b1;
      repeat (10) step();
      checks++;
      if (high_ber_count !== 16'd1) begin
         errors++;
         $display("FAIL high_ber_hold: got %0d want 1", high_ber_count);
      end
      rx_high_ber = 1'b0; step();
      rx_high_ber = 1'b1; step();
      rx_high_ber = 1'b0;
      checks++;
      if (high_ber_count !== 16'd2) begin
         errors++;
         $display("FAIL high_ber_edge2: got %0d want 2", high_ber_count);
      end
      clear_counters = 1'b1;
      rx_bad_block   = 1'b1;
      rx_error_count = 7'd9;
      step();
      clear_counters = 1'b0;
      rx_bad_block   = 1'b0;
      rx_error_count = 7'd0;
      checks++;
      if ({link_down_count, bad_block_count, seq_error_count, error_total, high_ber_count} !== 80'd0) begin
         errors++;
         $display("FAIL clear_all: got %0d %0d %0d %0d %0d, want all 0",
                  link_down_count, bad_block_count, seq_error_count, error_total, high_ber_count);
      end
      step();
      checks++;
      if (bad_block_count !== 16'd0 || error_total !== 16'd0) begin
         errors++;
         $display("FAIL clear_after: got bb=%0d et=%0d, want 0/0", bad_block_count, error_total);
      end
   endtask

   initial begin
      test_reset();
      test_debounce();
      test_glitch();
      test_lock_timeout();
      test_link_drops();
      test_accumulate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
